// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared mode encodings for the clock-enable generator
//
// Purpose: per-channel mode type and encodings used by clk_gen and its bench.
// Ports:   none (package).
package clk_gen_pkg;

  typedef logic [1:0] cg_mode_t;

  localparam cg_mode_t CG_MODE_TOGGLE = 2'b00;  // free-running square wave
  localparam cg_mode_t CG_MODE_TICK   = 2'b01;  // one-cycle strobe, level held
  localparam cg_mode_t CG_MODE_STEP   = 2'b10;  // one event per button press
  localparam cg_mode_t CG_MODE_HOLD   = 2'b11;  // freeze counter and level

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchroniser, debouncer and press-edge detector
//
// Purpose: turns the raw active-low board button into a clean active-high
//          level and a one-cycle pulse on each debounced press.
// Ports:   clk        - reference clock, rising edge
//          rst        - asynchronous active-low reset
//          raw_n      - raw asynchronous button, low = pressed
//          level      - debounced level, 1 = pressed
//          rise_pulse - one-cycle pulse, coincident with level rising
module btn_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic rise_pulse
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  // The synchroniser carries the raw active-low level, so its reset value 1
  // means "released"; inversion happens after the second flop.
  logic             r_sync1;
  logic             r_sync2;
  logic [DEB_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             w_pressed;

  assign w_pressed = ~r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= raw_n;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (w_pressed == r_level) begin
        // Any bounce back to the current level restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == DEB_MAX) begin
        r_cnt   <= '0;
        r_level <= w_pressed;
        // Registering the edge here lines the pulse up with the level change.
        r_rise  <= w_pressed;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_rise;

endmodule

// File: rtl/clk_gen.sv
// rtl/clk_gen.sv - multi-channel clock-enable / slow-clock generator
//
// Purpose: per-channel programmable divider producing a square level and a
//          one-cycle event strobe, with tick, button-step and hold modes.
// Ports:   cgi_clk    - fast reference clock, rising edge
//          cgi_rst    - asynchronous active-low reset
//          cgi_div    - per-channel divisor, channel k at [k*CNT_W +: CNT_W]
//          cgi_mode   - per-channel mode, channel k at [2k+1:2k]
//          cgi_clr    - synchronous clear of counters and outputs
//          cgi_btn    - raw active-low step button
//          cgo_out    - per-channel square / stepped level
//          cgo_tick   - per-channel one-cycle event strobe
//          cgo_btn_db - debounced button level, 1 = pressed
module clk_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic                    cgi_clk,
  input  logic                    cgi_rst,
  input  logic [NUM_CH*CNT_W-1:0] cgi_div,
  input  logic [NUM_CH*2-1:0]     cgi_mode,
  input  logic                    cgi_clr,
  input  logic                    cgi_btn,
  output logic [NUM_CH-1:0]       cgo_out,
  output logic [NUM_CH-1:0]       cgo_tick,
  output logic                    cgo_btn_db
);

  logic w_btn_level;
  logic w_step;

  // One debouncer serves every step-mode channel.
  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_btn_debounce (
    .clk        (cgi_clk),
    .rst        (cgi_rst),
    .raw_n      (cgi_btn),
    .level      (w_btn_level),
    .rise_pulse (w_step)
  );

  assign cgo_btn_db = w_btn_level;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    cg_mode_t         r_mode;
    logic             r_out;
    logic             r_tick;
    logic [CNT_W-1:0] w_div;
    cg_mode_t         w_mode;
    logic             w_wrap;

    assign w_div  = cgi_div[k*CNT_W +: CNT_W];
    assign w_mode = cgi_mode[2*k +: 2];
    // >= rather than == so a divisor shrunk below the current count wraps
    // at once instead of running through the whole counter range.
    assign w_wrap = (w_div != '0) && (r_cnt >= (w_div - CNT_W'(1)));

    always_ff @(posedge cgi_clk or negedge cgi_rst) begin
      if (!cgi_rst) begin
        r_cnt  <= '0;
        r_mode <= CG_MODE_TOGGLE;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_mode <= w_mode;
        r_tick <= 1'b0;
        if (cgi_clr) begin
          r_cnt <= '0;
          r_out <= 1'b0;
        end else if (w_mode != r_mode) begin
          // Restart cleanly in the new mode; the level is left as it was.
          r_cnt <= '0;
        end else begin
          case (w_mode)
            CG_MODE_TOGGLE, CG_MODE_TICK: begin
              if (w_div == '0) begin
                r_cnt <= '0;
              end else if (w_wrap) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                if (w_mode == CG_MODE_TOGGLE) begin
                  r_out <= ~r_out;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            CG_MODE_STEP: begin
              r_cnt <= '0;
              if (w_step) begin
                r_out  <= ~r_out;
                r_tick <= 1'b1;
              end
            end
            default: begin
              r_cnt <= r_cnt;
            end
          endcase
        end
      end
    end

    assign cgo_out[k]  = r_out;
    assign cgo_tick[k] = r_tick;
  end

endmodule

// File: tb/tb_clk_gen.sv
// tb/tb_clk_gen.sv - scoreboard bench for clk_gen
module tb_clk_gen;
  import clk_gen_pkg::*;

  localparam int NUM_CH     = 2;
  localparam int CNT_W      = 8;
  localparam int DEB_CYCLES = 8;
  localparam int DEB_W      = 4;

  logic                    cgi_clk = 1'b0;
  logic                    cgi_rst;
  logic [NUM_CH*CNT_W-1:0] cgi_div;
  logic [NUM_CH*2-1:0]     cgi_mode;
  logic                    cgi_clr;
  logic                    cgi_btn;
  logic [NUM_CH-1:0]       cgo_out;
  logic [NUM_CH-1:0]       cgo_tick;
  logic                    cgo_btn_db;

  clk_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) dut (
    .cgi_clk    (cgi_clk),
    .cgi_rst    (cgi_rst),
    .cgi_div    (cgi_div),
    .cgi_mode   (cgi_mode),
    .cgi_clr    (cgi_clr),
    .cgi_btn    (cgi_btn),
    .cgo_out    (cgo_out),
    .cgo_tick   (cgo_tick),
    .cgo_btn_db (cgo_btn_db)
  );

  always #5 cgi_clk = ~cgi_clk;

  typedef struct packed {
    logic tick;
    logic out;
    logic db;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Advance one active edge and land on the following falling edge.
  task automatic step_cycle();
    @(posedge cgi_clk);
    @(negedge cgi_clk);
  endtask

  task automatic test_reset();
    cgi_rst  = 1'b0;
    cgi_clr  = 1'b0;
    cgi_btn  = 1'b1;
    cgi_div  = {8'd0, 8'd3};
    cgi_mode = {CG_MODE_HOLD, CG_MODE_TOGGLE};
    repeat (2) @(negedge cgi_clk);
    checks++;
    if (cgo_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_out: got %b expected 00", cgo_out);
    end
    checks++;
    if (cgo_tick !== 2'b00) begin
      errors++;
      $display("FAIL reset_tick: got %b expected 00", cgo_tick);
    end
    checks++;
    if (cgo_btn_db !== 1'b0) begin
      errors++;
      $display("FAIL reset_btn_db: got %b expected 0", cgo_btn_db);
    end
  endtask

  task automatic test_toggle();
    for (int c = 1; c <= 13; c++) q.push_back('{(c % 3) == 0, ((c / 3) % 2) == 1, 1'b0});
    cgi_rst = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL toggle cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[0], cgo_out[0], e.tick, e.out);
      end
    end
  endtask

  task automatic test_tick_div();
    cgi_mode[3:2] = CG_MODE_TICK;
    cgi_div[15:8] = 8'd1;
    // First edge is the mode change and never fires.
    for (int c = 1; c <= 8; c++) q.push_back('{c >= 2, 1'b0, 1'b0});
    for (int c = 1; c <= 8; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[1], cgo_out[1]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL tick_div1 cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[1], cgo_out[1], e.tick, e.out);
      end
    end
    cgi_div[15:8] = 8'd0;
    for (int c = 1; c <= 6; c++) q.push_back('{1'b0, 1'b0, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[1], cgo_out[1]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL tick_div0 cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[1], cgo_out[1], e.tick, e.out);
      end
    end
  endtask

  task automatic test_div_shrink();
    cgi_div[7:0] = 8'd10;
    cgi_clr = 1'b1;
    step_cycle();
    cgi_clr = 1'b0;
    // Seven quiet edges leave the counter at 7, below the wrap point of 9.
    for (int c = 1; c <= 7; c++) q.push_back('{1'b0, 1'b0, 1'b0});
    for (int c = 1; c <= 7; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL shrink_pre cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[0], cgo_out[0], e.tick, e.out);
      end
    end
    cgi_div[7:0] = 8'd4;
    for (int c = 1; c <= 9; c++)
      q.push_back('{(c == 1) || (c == 5) || (c == 9), (c < 5) || (c == 9), 1'b0});
    for (int c = 1; c <= 9; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL shrink cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[0], cgo_out[0], e.tick, e.out);
      end
    end
  endtask

  task automatic test_clr_pending();
    cgi_clr = 1'b1;
    step_cycle();
    cgi_clr = 1'b0;
    for (int c = 1; c <= 7; c++) q.push_back('{c == 4, c >= 4, 1'b0});
    for (int c = 1; c <= 7; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL clr_run cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[0], cgo_out[0], e.tick, e.out);
      end
    end
    // Counter sits at 3 now, so this edge would wrap without the clear.
    cgi_clr = 1'b1;
    q.push_back('{1'b0, 1'b0, 1'b0});
    step_cycle();
    e = q.pop_front();
    checks++;
    if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
      errors++;
      $display("FAIL clr_pending: tick/out got %b%b expected %b%b",
               cgo_tick[0], cgo_out[0], e.tick, e.out);
    end
    cgi_clr = 1'b0;
    for (int c = 1; c <= 4; c++) q.push_back('{c == 4, c == 4, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL clr_after cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[0], cgo_out[0], e.tick, e.out);
      end
    end
  endtask

  task automatic test_step();
    cgi_mode = {CG_MODE_STEP, CG_MODE_HOLD};
    repeat (2) step_cycle();
    // Bouncy press: never stable for DEB_CYCLES, so nothing may happen.
    for (int b = 0; b < 6; b++) begin
      cgi_btn = b[0];
      for (int c = 0; c < 3; c++) begin
        q.push_back('{1'b0, 1'b0, 1'b0});
        step_cycle();
        e = q.pop_front();
        checks++;
        if ({cgo_tick[1], cgo_out[1], cgo_btn_db} !== {e.tick, e.out, e.db}) begin
          errors++;
          $display("FAIL bounce b%0d c%0d: tick/out/db got %b%b%b expected %b%b%b",
                   b, c, cgo_tick[1], cgo_out[1], cgo_btn_db, e.tick, e.out, e.db);
        end
      end
    end
    cgi_btn = 1'b1;
    repeat (10) step_cycle();
    cgi_btn = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      q.push_back('{c == 11, c >= 11, c >= 10});
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[1], cgo_out[1], cgo_btn_db} !== {e.tick, e.out, e.db}) begin
        errors++;
        $display("FAIL press cyc %0d: tick/out/db got %b%b%b expected %b%b%b",
                 c, cgo_tick[1], cgo_out[1], cgo_btn_db, e.tick, e.out, e.db);
      end
    end
    cgi_btn = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      q.push_back('{1'b0, 1'b1, c < 10});
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[1], cgo_out[1], cgo_btn_db} !== {e.tick, e.out, e.db}) begin
        errors++;
        $display("FAIL release cyc %0d: tick/out/db got %b%b%b expected %b%b%b",
                 c, cgo_tick[1], cgo_out[1], cgo_btn_db, e.tick, e.out, e.db);
      end
    end
  endtask

  task automatic test_reset_async();
    cgi_mode[1:0] = CG_MODE_TOGGLE;
    cgi_div[7:0]  = 8'd5;
    cgi_clr = 1'b1;
    step_cycle();
    cgi_clr = 1'b0;
    for (int c = 1; c <= 5; c++) q.push_back('{c == 5, c == 5, 1'b0});
    for (int c = 1; c <= 5; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL rst_pre cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[0], cgo_out[0], e.tick, e.out);
      end
    end
    // Both outputs are high here; reset must drop them before the next edge.
    #1 cgi_rst = 1'b0;
    #1;
    checks++;
    if ({cgo_tick, cgo_out} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async: tick/out got %b/%b expected 00/00", cgo_tick, cgo_out);
    end
    @(negedge cgi_clk);
    cgi_rst = 1'b1;
    for (int c = 1; c <= 10; c++) q.push_back('{(c == 5) || (c == 10), (c >= 5) && (c < 10), 1'b0});
    for (int c = 1; c <= 10; c++) begin
      step_cycle();
      e = q.pop_front();
      checks++;
      if ({cgo_tick[0], cgo_out[0]} !== {e.tick, e.out}) begin
        errors++;
        $display("FAIL rst_after cyc %0d: tick/out got %b%b expected %b%b",
                 c, cgo_tick[0], cgo_out[0], e.tick, e.out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_tick_div();
    test_div_shrink();
    test_clr_pending();
    test_step();
    test_reset_async();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
